// File: rtl/ctrl_pkg.sv
// Shared constants for the hardwired control unit: opcodes, ALU function codes,
// sequencer state encoding and instruction classes.
package ctrl_pkg;

    localparam int CTRL_OPCODE_W = 5;
    localparam int CTRL_ALU_OP_W = 5;

    localparam logic [CTRL_OPCODE_W-1:0] OP_ADD  = 5'd3;
    localparam logic [CTRL_OPCODE_W-1:0] OP_SUB  = 5'd4;
    localparam logic [CTRL_OPCODE_W-1:0] OP_AND  = 5'd5;
    localparam logic [CTRL_OPCODE_W-1:0] OP_OR   = 5'd6;
    localparam logic [CTRL_OPCODE_W-1:0] OP_ROR  = 5'd7;
    localparam logic [CTRL_OPCODE_W-1:0] OP_ROL  = 5'd8;
    localparam logic [CTRL_OPCODE_W-1:0] OP_SHR  = 5'd9;
    localparam logic [CTRL_OPCODE_W-1:0] OP_SHRA = 5'd10;
    localparam logic [CTRL_OPCODE_W-1:0] OP_SHL  = 5'd11;
    localparam logic [CTRL_OPCODE_W-1:0] OP_MUL  = 5'd15;
    localparam logic [CTRL_OPCODE_W-1:0] OP_DIV  = 5'd16;
    localparam logic [CTRL_OPCODE_W-1:0] OP_NEG  = 5'd17;
    localparam logic [CTRL_OPCODE_W-1:0] OP_NOT  = 5'd18;
    localparam logic [CTRL_OPCODE_W-1:0] OP_NOP  = 5'd26;
    localparam logic [CTRL_OPCODE_W-1:0] OP_HALT = 5'd27;

    localparam logic [CTRL_ALU_OP_W-1:0] ALU_NOP  = 5'd0;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_ADD  = 5'd1;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_SUB  = 5'd2;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_AND  = 5'd3;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_OR   = 5'd4;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_SHL  = 5'd5;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_SHR  = 5'd6;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_SHRA = 5'd7;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_ROL  = 5'd8;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_ROR  = 5'd9;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_MUL  = 5'd10;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_DIV  = 5'd11;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_NEG  = 5'd12;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_NOT  = 5'd13;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decode into instruction class and ALU function.
module opcode_decoder
    import ctrl_pkg::*;
(
    input  logic [CTRL_OPCODE_W-1:0] opcode,
    output op_class_t                op_class,
    output logic [CTRL_ALU_OP_W-1:0] alu_fn
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        alu_fn   = ALU_NOP;
        case (opcode)
            OP_ADD:  begin op_class = CLS_RTYPE;  alu_fn = ALU_ADD;  end
            OP_SUB:  begin op_class = CLS_RTYPE;  alu_fn = ALU_SUB;  end
            OP_AND:  begin op_class = CLS_RTYPE;  alu_fn = ALU_AND;  end
            OP_OR:   begin op_class = CLS_RTYPE;  alu_fn = ALU_OR;   end
            OP_SHL:  begin op_class = CLS_RTYPE;  alu_fn = ALU_SHL;  end
            OP_SHR:  begin op_class = CLS_RTYPE;  alu_fn = ALU_SHR;  end
            OP_SHRA: begin op_class = CLS_RTYPE;  alu_fn = ALU_SHRA; end
            OP_ROL:  begin op_class = CLS_RTYPE;  alu_fn = ALU_ROL;  end
            OP_ROR:  begin op_class = CLS_RTYPE;  alu_fn = ALU_ROR;  end
            OP_MUL:  begin op_class = CLS_MULDIV; alu_fn = ALU_MUL;  end
            OP_DIV:  begin op_class = CLS_MULDIV; alu_fn = ALU_DIV;  end
            OP_NEG:  begin op_class = CLS_UNARY;  alu_fn = ALU_NEG;  end
            OP_NOT:  begin op_class = CLS_UNARY;  alu_fn = ALU_NOT;  end
            OP_NOP:  op_class = CLS_NOP;
            OP_HALT: op_class = CLS_HALT;
            default: op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit for the bus-based datapath.
// Optional CTRL_MEM_WAIT_EN: stretch T1 until mem_ready.
//
// state | meaning
// IDLE  | waiting for run
// T0    | PC -> MAR, Z <= PC+1
// T1    | Z -> PC, memory read into MDR
// T2    | MDR -> IR, class decided for the branch below
// T3-T6 | execute steps, content depends on instruction class
// HALT  | stopped until clear
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = CTRL_OPCODE_W,
    parameter int ALU_OP_W = CTRL_ALU_OP_W
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                MDRout,
    output logic                MARin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                LOin,
    output logic                HIin,
    output logic                IncPC,
    output logic                Read,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                halted,
    output logic                illegal_op
);

    state_t                   state_q, state_d;
    op_class_t                dec_class;
    logic [CTRL_ALU_OP_W-1:0] dec_alu;
    logic [CTRL_OPCODE_W-1:0] opcode;
    logic                     illegal_d;
    logic                     t1_first;
    state_t                   end_next;

    logic unused_ir;
    assign unused_ir = ^ir[31-OPCODE_W:0];
    assign opcode    = CTRL_OPCODE_W'(ir[31 -: OPCODE_W]);

    opcode_decoder u_opcode_decoder (
        .opcode   (opcode),
        .op_class (dec_class),
        .alu_fn   (dec_alu)
    );

`ifdef CTRL_MEM_WAIT_EN
    // Set while T1 is being stretched, so PC is only reloaded on the first T1 cycle.
    logic t1_wait_q;
    always_ff @(posedge clock or posedge clear) begin
        if (clear) t1_wait_q <= 1'b0;
        else       t1_wait_q <= (state_q == ST_T1);
    end
    assign t1_first = ~t1_wait_q;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign t1_first         = 1'b1;
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q    <= ST_IDLE;
            illegal_op <= 1'b0;
        end else begin
            state_q    <= state_d;
            illegal_op <= illegal_d;
        end
    end

    assign end_next = run ? ST_T0 : ST_IDLE;

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
`ifdef CTRL_MEM_WAIT_EN
            ST_T1:   if (mem_ready) state_d = ST_T2;
`else
            ST_T1:   state_d = ST_T2;
`endif
            ST_T2: begin
                case (dec_class)
                    CLS_RTYPE, CLS_MULDIV, CLS_UNARY: state_d = ST_T3;
                    CLS_HALT:                         state_d = ST_HALT;
                    CLS_ILLEGAL: begin
                        illegal_d = 1'b1;
                        state_d   = end_next;
                    end
                    default:                          state_d = end_next;
                endcase
            end
            ST_T3:   state_d = ST_T4;
            ST_T4:   state_d = (dec_class == CLS_UNARY) ? end_next : ST_T5;
            ST_T5:   state_d = (dec_class == CLS_MULDIV) ? ST_T6 : end_next;
            ST_T6:   state_d = end_next;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        halted   = 1'b0;
        alu_op   = ALU_OP_W'(ALU_NOP);
        case (state_q)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            ST_T1: begin
                Zlowout = t1_first;
                PCin    = t1_first;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                if (dec_class == CLS_RTYPE || dec_class == CLS_MULDIV) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (dec_class == CLS_UNARY) begin
                    Grb    = 1'b1;
                    Rout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = ALU_OP_W'(dec_alu);
                end
            end
            ST_T4: begin
                if (dec_class == CLS_RTYPE || dec_class == CLS_MULDIV) begin
                    Grc    = 1'b1;
                    Rout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = ALU_OP_W'(dec_alu);
                end else if (dec_class == CLS_UNARY) begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end
            end
            ST_T5: begin
                if (dec_class == CLS_RTYPE) begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end else if (dec_class == CLS_MULDIV) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end
            end
            ST_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed cycle-by-cycle check of control_sequencer strobes against hand-built tables.
module tb_control_sequencer;
    import ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        clear, run, mem_ready;
    logic [31:0] ir;
    logic        PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin;
    logic        Yin, Zin, LOin, HIin, IncPC, Read, Gra, Grb, Grc, Rin, Rout;
    logic        halted, illegal_op;
    logic [4:0]  alu_op;

    int checks = 0;
    int errors = 0;

    control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .LOin(LOin), .HIin(HIin), .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .halted(halted),
        .illegal_op(illegal_op)
    );

    always #5 clock = ~clock;

    localparam logic [20:0] M_PCOUT    = 21'h1 << 20;
    localparam logic [20:0] M_ZLOWOUT  = 21'h1 << 19;
    localparam logic [20:0] M_ZHIGHOUT = 21'h1 << 18;
    localparam logic [20:0] M_MDROUT   = 21'h1 << 17;
    localparam logic [20:0] M_MARIN    = 21'h1 << 16;
    localparam logic [20:0] M_PCIN     = 21'h1 << 15;
    localparam logic [20:0] M_MDRIN    = 21'h1 << 14;
    localparam logic [20:0] M_IRIN     = 21'h1 << 13;
    localparam logic [20:0] M_YIN      = 21'h1 << 12;
    localparam logic [20:0] M_ZIN      = 21'h1 << 11;
    localparam logic [20:0] M_LOIN     = 21'h1 << 10;
    localparam logic [20:0] M_HIIN     = 21'h1 << 9;
    localparam logic [20:0] M_INCPC    = 21'h1 << 8;
    localparam logic [20:0] M_READ     = 21'h1 << 7;
    localparam logic [20:0] M_GRA      = 21'h1 << 6;
    localparam logic [20:0] M_GRB      = 21'h1 << 5;
    localparam logic [20:0] M_GRC      = 21'h1 << 4;
    localparam logic [20:0] M_RIN      = 21'h1 << 3;
    localparam logic [20:0] M_ROUT     = 21'h1 << 2;
    localparam logic [20:0] M_HALTED   = 21'h1 << 1;
    localparam logic [20:0] M_ILLEGAL  = 21'h1;

    localparam logic [20:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [20:0] F1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
    localparam logic [20:0] F2 = M_MDROUT | M_IRIN;
    localparam logic [20:0] NONE = 21'h0;

    function automatic logic [31:0] observed();
        return {6'd0, alu_op, PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin,
                IRin, Yin, Zin, LOin, HIin, IncPC, Read, Gra, Grb, Grc, Rin, Rout,
                halted, illegal_op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [20:0] c, input logic [4:0] a);
        @(negedge clock);
        chk(tag, observed(), {6'd0, a, c});
    endtask

    function automatic logic [31:0] instr(input logic [4:0] opc);
        return {opc, 4'd1, 4'd2, 4'd3, 15'd0};
    endfunction

    initial begin
        clear = 1'b1; run = 1'b0; mem_ready = 1'b1; ir = 32'd0;
        @(negedge clock);
        chk("reset", observed(), {6'd0, ALU_NOP, NONE});
        clear = 1'b0;
        cyc("idle0", NONE, ALU_NOP);
        cyc("idle1", NONE, ALU_NOP);

        ir = instr(OP_SHL); run = 1'b1;
        cyc("shl_t0", F0, ALU_NOP);
        cyc("shl_t1", F1, ALU_NOP);
        cyc("shl_t2", F2, ALU_NOP);
        cyc("shl_t3", M_GRB | M_ROUT | M_YIN, ALU_NOP);
        cyc("shl_t4", M_GRC | M_ROUT | M_ZIN, ALU_SHL);
        cyc("shl_t5", M_ZLOWOUT | M_GRA | M_RIN, ALU_NOP);
        cyc("shl_next_t0", F0, ALU_NOP);

        ir = instr(OP_MUL);
        cyc("mul_t1", F1, ALU_NOP);
        cyc("mul_t2", F2, ALU_NOP);
        cyc("mul_t3", M_GRB | M_ROUT | M_YIN, ALU_NOP);
        cyc("mul_t4", M_GRC | M_ROUT | M_ZIN, ALU_MUL);
        cyc("mul_t5", M_ZLOWOUT | M_LOIN, ALU_NOP);
        cyc("mul_t6", M_ZHIGHOUT | M_HIIN, ALU_NOP);
        cyc("mul_next_t0", F0, ALU_NOP);

        ir = instr(OP_NOT);
        cyc("not_t1", F1, ALU_NOP);
        cyc("not_t2", F2, ALU_NOP);
        cyc("not_t3", M_GRB | M_ROUT | M_ZIN, ALU_NOT);
        cyc("not_t4", M_ZLOWOUT | M_GRA | M_RIN, ALU_NOP);
        cyc("not_next_t0", F0, ALU_NOP);

        ir = instr(OP_NOP);
        cyc("nop_a_t1", F1, ALU_NOP);
        cyc("nop_a_t2", F2, ALU_NOP);
        cyc("nop_b_t0", F0, ALU_NOP);
        cyc("nop_b_t1", F1, ALU_NOP);
        cyc("nop_b_t2", F2, ALU_NOP);
        cyc("nop_next_t0", F0, ALU_NOP);

        ir = instr(5'b11111);
        cyc("ill_t1", F1, ALU_NOP);
        cyc("ill_t2", F2, ALU_NOP);
        cyc("ill_pulse", F0 | M_ILLEGAL, ALU_NOP);
        ir = instr(OP_HALT);
        cyc("halt_t1", F1, ALU_NOP);
        cyc("halt_t2", F2, ALU_NOP);
        for (int i = 0; i < 20; i++) begin
            run = (i % 3 != 1);
            cyc("halt_hold", M_HALTED, ALU_NOP);
        end
        clear = 1'b1;
        #1 chk("halt_clear_async", observed(), {6'd0, ALU_NOP, NONE});
        cyc("halt_clear_hold", NONE, ALU_NOP);
        run = 1'b0; clear = 1'b0;
        cyc("post_halt_idle0", NONE, ALU_NOP);
        cyc("post_halt_idle1", NONE, ALU_NOP);

        ir = instr(OP_ADD); run = 1'b1;
        cyc("add_t0", F0, ALU_NOP);
        cyc("add_t1", F1, ALU_NOP);
        cyc("add_t2", F2, ALU_NOP);
        cyc("add_t3", M_GRB | M_ROUT | M_YIN, ALU_NOP);
        cyc("add_t4", M_GRC | M_ROUT | M_ZIN, ALU_ADD);
        clear = 1'b1; run = 1'b0;
        #1 chk("clear_mid_t4", observed(), {6'd0, ALU_NOP, NONE});
        cyc("clear_hold", NONE, ALU_NOP);
        clear = 1'b0;
        cyc("clear_idle0", NONE, ALU_NOP);
        cyc("clear_idle1", NONE, ALU_NOP);

        ir = instr(OP_SUB); run = 1'b1;
        cyc("sub_t0", F0, ALU_NOP);
        run = 1'b0;
        cyc("sub_t1", F1, ALU_NOP);
        cyc("sub_t2", F2, ALU_NOP);
        cyc("sub_t3", M_GRB | M_ROUT | M_YIN, ALU_NOP);
        cyc("sub_t4", M_GRC | M_ROUT | M_ZIN, ALU_SUB);
        cyc("sub_t5", M_ZLOWOUT | M_GRA | M_RIN, ALU_NOP);
        cyc("sub_end_idle", NONE, ALU_NOP);
        cyc("sub_end_idle1", NONE, ALU_NOP);

`ifdef CTRL_MEM_WAIT_EN
        ir = instr(OP_NOP); mem_ready = 1'b0; run = 1'b1;
        cyc("wait_t0", F0, ALU_NOP);
        cyc("wait_t1_first", F1, ALU_NOP);
        cyc("wait_t1_2", M_READ | M_MDRIN, ALU_NOP);
        cyc("wait_t1_3", M_READ | M_MDRIN, ALU_NOP);
        cyc("wait_t1_4", M_READ | M_MDRIN, ALU_NOP);
        mem_ready = 1'b1;
        cyc("wait_t2", F2, ALU_NOP);
        run = 1'b0;
        cyc("wait_end_idle", NONE, ALU_NOP);
`else
        ir = instr(OP_NOP); mem_ready = 1'b0; run = 1'b1;
        cyc("nowait_t0", F0, ALU_NOP);
        cyc("nowait_t1", F1, ALU_NOP);
        cyc("nowait_t2", F2, ALU_NOP);
        run = 1'b0;
        cyc("nowait_end_idle", NONE, ALU_NOP);
        mem_ready = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
